mmio_timer: RTL and testbench

//   Memory-mapped timer peripheral. It is the responder to the MEM stage's data-bus initiator.
//   It decodes MemRead/MemWrite/Address/WriteData from the pipeline's MEM stage and returns ReadData.
//   It raises irqout, which MEM forwards to ID as the interrupt request.
//   It provides a reloadable up-counter (TH/TL), a control/status register (TCON) and a free-running SysTick.

---
 rtl/mmio_timer.sv | 172 +++++++++++++++++
 tb/tb_mmio_timer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_timer.sv
// ============================================================================
//  Module   : mmio_timer
//  Purpose  : Memory-mapped timer peripheral on the MEM-stage data bus.
//             Reloadable up-counter (TH/TL), control/status (TCON),
//             optional prescaler (PSC) and a free-running SYSTICK.
//  Options  : TIMER_PRESCALE_EN - adds the PSC register at +0xC and a
//             down-counting prescaler that gates the count tick.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mmio_timer #(
    parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
    parameter int unsigned PRESCALE_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        hit,
    output logic        irqout
);

    localparam logic [31:0] c_ADDR_TH      = BASE_ADDR;
    localparam logic [31:0] c_ADDR_TL      = BASE_ADDR + 32'h4;
    localparam logic [31:0] c_ADDR_TCON    = BASE_ADDR + 32'h8;
    localparam logic [31:0] c_ADDR_PSC     = BASE_ADDR + 32'hC;
    localparam logic [31:0] c_ADDR_SYSTICK = BASE_ADDR + 32'h10;
    localparam logic [31:0] c_TL_MAX       = 32'hFFFF_FFFF;

    logic [31:0] r_th;
    logic [31:0] r_tl;
    logic [2:0]  r_tcon;      // [0]=EN, [1]=IE, [2]=IRQ
    logic [31:0] r_systick;

    logic w_sel_th;
    logic w_sel_tl;
    logic w_sel_tcon;
    logic w_sel_psc;
    logic w_sel_systick;
    logic w_wr_th;
    logic w_wr_tl;
    logic w_wr_tcon;
    logic w_tick;
    logic w_ovf;
    logic w_irq_set;

    // Exact-match decode; misaligned or out-of-window addresses never match
    assign w_sel_th      = (Address == c_ADDR_TH);
    assign w_sel_tl      = (Address == c_ADDR_TL);
    assign w_sel_tcon    = (Address == c_ADDR_TCON);
    assign w_sel_systick = (Address == c_ADDR_SYSTICK);

`ifdef TIMER_PRESCALE_EN
    logic [PRESCALE_W-1:0] r_psc;
    logic [PRESCALE_W-1:0] r_psc_cnt;
    logic                  w_wr_psc;

    assign w_sel_psc = (Address == c_ADDR_PSC);
    assign w_wr_psc  = MemWrite && w_sel_psc;
    assign w_tick    = r_tcon[0] && (r_psc_cnt == '0);

    // Prescaler reload value, software writable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_psc <= '0;
        end else if (w_wr_psc) begin
            r_psc <= WriteData[PRESCALE_W-1:0];
        end
    end

    // Prescaler down-counter: restarts on PSC write, frozen while EN=0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_psc_cnt <= '0;
        end else if (w_wr_psc) begin
            r_psc_cnt <= WriteData[PRESCALE_W-1:0];
        end else if (r_tcon[0]) begin
            if (r_psc_cnt == '0) begin
                r_psc_cnt <= r_psc;
            end else begin
                r_psc_cnt <= r_psc_cnt - 1'b1;
            end
        end
    end
`else
    // Offset +0xC is unmapped; a zero prescaler width is treated as no timer
    assign w_sel_psc = 1'b0;
    assign w_tick    = r_tcon[0] && (PRESCALE_W != 0);
`endif

    assign hit = w_sel_th || w_sel_tl || w_sel_tcon || w_sel_psc || w_sel_systick;

    assign w_wr_th   = MemWrite && w_sel_th;
    assign w_wr_tl   = MemWrite && w_sel_tl;
    assign w_wr_tcon = MemWrite && w_sel_tcon;

    assign w_ovf     = w_tick && (r_tl == c_TL_MAX);
    assign w_irq_set = w_ovf && r_tcon[1];

    assign irqout = r_tcon[2];

    // Zero-latency read mux; shows pre-write contents during a store
    always_comb begin
        ReadData = 32'h0;
        if (MemRead) begin
            if (w_sel_th) begin
                ReadData = r_th;
            end else if (w_sel_tl) begin
                ReadData = r_tl;
            end else if (w_sel_tcon) begin
                ReadData = {29'h0, r_tcon};
            end else if (w_sel_systick) begin
                ReadData = r_systick;
            end
`ifdef TIMER_PRESCALE_EN
            else if (w_sel_psc) begin
                ReadData = {{(32-PRESCALE_W){1'b0}}, r_psc};
            end
`endif
        end
    end

    // Reload value; a write during overflow takes effect on the next overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_th <= 32'h0;
        end else if (w_wr_th) begin
            r_th <= WriteData;
        end
    end

    // Count register: CPU write beats the tick, overflow reloads from TH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tl <= 32'h0;
        end else if (w_wr_tl) begin
            r_tl <= WriteData;
        end else if (w_ovf) begin
            r_tl <= r_th;
        end else if (w_tick) begin
            r_tl <= r_tl + 32'h1;
        end
    end

    // Control/status: IRQ is write-0-to-clear and a simultaneous set wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tcon <= 3'b000;
        end else if (w_wr_tcon) begin
            r_tcon <= {(WriteData[2] && r_tcon[2]) || w_irq_set, WriteData[1:0]};
        end else if (w_irq_set) begin
            r_tcon[2] <= 1'b1;
        end
    end

    // Free-running cycle counter, independent of EN and not writable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_systick <= 32'h0;
        end else begin
            r_systick <= r_systick + 32'h1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mmio_timer.sv
// ============================================================================
//  Module   : tb_mmio_timer
//  Purpose  : Directed self-checking bench for mmio_timer.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mmio_timer;

    localparam logic [31:0] c_BASE = 32'h4000_0000;
    localparam logic [31:0] c_TH   = c_BASE;
    localparam logic [31:0] c_TL   = c_BASE + 32'h4;
    localparam logic [31:0] c_TCON = c_BASE + 32'h8;
    localparam logic [31:0] c_PSC  = c_BASE + 32'hC;
    localparam logic [31:0] c_SYST = c_BASE + 32'h10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        hit;
    logic        irqout;

    int checks = 0;
    int errors = 0;

    // Reference cycle counter for SYSTICK
    logic [31:0] tb_tick;

    mmio_timer #(
        .BASE_ADDR  (c_BASE),
        .PRESCALE_W (8)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Address   (Address),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .hit       (hit),
        .irqout    (irqout)
    );

    always #5 clk = ~clk;

    // SYSTICK reference: cleared by reset, +1 on every rising edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_tick <= 32'h0;
        else        tb_tick <= tb_tick + 32'h1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Combinational read at the current time (between clock edges)
    task automatic rd(input logic [31:0] addr, input string tag, input logic [31:0] exp);
        Address = addr;
        MemRead = 1'b1;
        #1;
        chk(tag, ReadData, exp);
        MemRead = 1'b0;
    endtask

    // Store committed on the next rising edge; returns 1 time unit after it
    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        Address   = addr;
        WriteData = data;
        MemWrite  = 1'b1;
        @(posedge clk);
        #1;
        MemWrite  = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        Address = 32'h0; WriteData = 32'h0;
        step(3);

        // ---- Reset state ----
        rd(c_TH,   "rst_th",   32'h0);
        rd(c_TL,   "rst_tl",   32'h0);
        rd(c_TCON, "rst_tcon", 32'h0);
        rd(c_SYST, "rst_systick", 32'h0);
        chk("rst_irq", {31'h0, irqout}, 32'h0);
        rst_n = 1'b1;
        #1;
        rd(c_SYST, "systick_0", 32'h0);
        step(1);
        rd(c_SYST, "systick_1", 32'h1);
        step(3);
        rd(c_SYST, "systick_4", tb_tick);
        chk("systick_4_abs", tb_tick, 32'h4);

        // ---- Count up and overflow with IE=1 ----
        wr(c_TH, 32'hFFFF_FFF0);
        wr(c_TL, 32'hFFFF_FFFD);
        rd(c_TH, "th_wr", 32'hFFFF_FFF0);
        wr(c_TCON, 32'h3);
        rd(c_TL, "tl_en0", 32'hFFFF_FFFD);
        step(1);
        rd(c_TL, "tl_fffe", 32'hFFFF_FFFE);
        step(1);
        rd(c_TL, "tl_ffff", 32'hFFFF_FFFF);
        chk("irq_pre_ovf", {31'h0, irqout}, 32'h0);
        step(1);
        rd(c_TL, "tl_reload", 32'hFFFF_FFF0);
        chk("irq_ovf", {31'h0, irqout}, 32'h1);
        rd(c_TCON, "tcon_irq", 32'h7);

        // ---- IRQ clear, and set winning over a same-cycle clear ----
        wr(c_TCON, 32'h3);
        chk("irq_clr", {31'h0, irqout}, 32'h0);
        rd(c_TCON, "tcon_clr", 32'h3);
        wr(c_TL, 32'hFFFF_FFFF);
        wr(c_TCON, 32'h3);
        chk("irq_set_wins", {31'h0, irqout}, 32'h1);
        rd(c_TL, "tl_ovf_tcon", 32'hFFFF_FFF0);
        wr(c_TCON, 32'h3);
        chk("irq_clr2", {31'h0, irqout}, 32'h0);

        // ---- Overflow with IE=0, TL write beats tick ----
        wr(c_TCON, 32'h1);
        wr(c_TH, 32'h0000_0100);
        wr(c_TL, 32'hFFFF_FFFE);
        step(1);
        rd(c_TL, "tl_ie0_ffff", 32'hFFFF_FFFF);
        step(1);
        rd(c_TL, "tl_ie0_reload", 32'h0000_0100);
        chk("irq_ie0", {31'h0, irqout}, 32'h0);
        rd(c_TCON, "tcon_ie0", 32'h1);
        wr(c_TL, 32'h5);
        rd(c_TL, "tl_wr_wins", 32'h5);
        step(1);
        rd(c_TL, "tl_after_wr", 32'h6);

        // ---- TH write during overflow reloads the old TH ----
        wr(c_TL, 32'hFFFF_FFFF);
        wr(c_TH, 32'h0000_0200);
        rd(c_TL, "tl_old_th", 32'h0000_0100);
        rd(c_TH, "th_new", 32'h0000_0200);

        // ---- Simultaneous read and write shows pre-write value ----
        Address = c_TH; WriteData = 32'h0000_0300;
        MemRead = 1'b1; MemWrite = 1'b1;
        #1;
        chk("rw_prewrite", ReadData, 32'h0000_0200);
        @(posedge clk);
        #1;
        MemRead = 1'b0; MemWrite = 1'b0;
        rd(c_TH, "rw_postwrite", 32'h0000_0300);

        // ---- EN=0 holds TL ----
        wr(c_TCON, 32'h0);
        step(2);
        rd(c_TL, "tl_hold", 32'h0000_0102);
        chk("irq_hold", {31'h0, irqout}, 32'h0);

        // ---- Decode limits and SYSTICK write ignored ----
        rd(c_BASE + 32'h14, "rd_off14", 32'h0);
        chk("hit_off14", {31'h0, hit}, 32'h0);
        rd(c_BASE + 32'h2, "rd_unaligned", 32'h0);
        chk("hit_unaligned", {31'h0, hit}, 32'h0);
`ifndef TIMER_PRESCALE_EN
        rd(c_PSC, "rd_psc_unmapped", 32'h0);
        chk("hit_psc_unmapped", {31'h0, hit}, 32'h0);
`endif
        Address = c_SYST; MemRead = 1'b0;
        #1;
        chk("hit_systick", {31'h0, hit}, 32'h1);
        chk("rd_noread", ReadData, 32'h0);
        wr(c_SYST, 32'h0);
        rd(c_SYST, "systick_wr_ignored", tb_tick);
        step(5);
        rd(c_SYST, "systick_running", tb_tick);

        // ---- Asynchronous reset mid-count ----
        wr(c_TH, 32'h55);
        wr(c_TCON, 32'h3);
        step(2);
        rst_n = 1'b0;
        #1;
        rd(c_TH,   "arst_th",   32'h0);
        rd(c_TL,   "arst_tl",   32'h0);
        rd(c_TCON, "arst_tcon", 32'h0);
        rd(c_SYST, "arst_systick", 32'h0);
        chk("arst_irq", {31'h0, irqout}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        rd(c_TH,   "rel_th",   32'h0);
        rd(c_TL,   "rel_tl",   32'h0);
        rd(c_TCON, "rel_tcon", 32'h0);

`ifdef TIMER_PRESCALE_EN
        // ---- Prescaler: PSC=3 gives one tick every 4 cycles ----
        wr(c_PSC, 32'h3);
        rd(c_PSC, "psc_rd", 32'h3);
        wr(c_TL, 32'h0);
        wr(c_TCON, 32'h1);
        step(3);
        rd(c_TL, "psc_tl_0", 32'h0);
        step(1);
        rd(c_TL, "psc_tl_1", 32'h1);
        step(3);
        rd(c_TL, "psc_tl_1b", 32'h1);
        step(1);
        rd(c_TL, "psc_tl_2", 32'h2);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;
        rd(c_PSC, "psc_rst", 32'h0);
        rd(c_TL,  "psc_rst_tl", 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
